nios_cpu_mul_combine: RTL and testbench
=======================================

Name: nios_cpu_mul_combine

Overview:
- Downstream of the M-stage multiplier cell.
- Consumes the three registered 16x16 partial products (lo*lo, lo*hi, hi*lo) and produces the A-stage result.
- MUL returns the low 32 bits in one cycle.
- MULXUU/MULXSS/MULXSU return the high 32 bits. The missing hi*hi product is built by an iterative shift-add engine, with signed correction, while the pipeline is stalled.

Parameters:
- ITER_CYCLES, 16, iterations of the hi*hi engine (fixed by radix; 8 when the radix-4 macro is defined; not user-overridable).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- M_mul_cell_p1  in  32  src1[15:0]*src2[15:0], unsigned
- M_mul_cell_p2  in  32  src1[15:0]*src2[31:16], unsigned
- M_mul_cell_p3  in  32  src1[31:16]*src2[15:0], unsigned
- M_src1  in  32  operand A, same value that produced p1..p3
- M_src2  in  32  operand B, same value that produced p1..p3
- M_valid  in  1  M stage holds a multiply instruction
- M_op  in  2  00 MUL, 01 MULXUU, 10 MULXSS, 11 MULXSU
- A_en  in  1  pipeline advance enable
- A_mul_result  out  32  product word
- A_mul_valid  out  1  A_mul_result valid, one-cycle pulse
- A_mul_stall  out  1  high-word engine busy; pipeline must freeze

Behaviour:
- Reset (async, reset_n=0): state IDLE; A_mul_result=0, A_mul_valid=0, A_mul_stall=0; all internal registers 0. Reset mid-iteration aborts the operation; no valid is produced.
- Accept: rising edge with M_valid=1, A_en=1, state IDLE.
- M_valid or A_en low in IDLE: A_mul_valid=0, A_mul_result holds.
- MUL (op 00):
  - A_mul_result <= p1 + ({p2[15:0]+p3[15:0]} << 16), mod 2^32.
  - A_mul_valid=1 the cycle after accept; no stall; back-to-back accepts allowed.
- MULX (op != 00), FSM IDLE -> ITER -> FIX -> DONE -> IDLE:
  - At accept: latch src1, src2, op, p1..p3; load multiplicand = src1[31:16], multiplier = src2[31:16], acc = 0, count = 0.
  - A_mul_stall goes high the cycle after accept.
  - ITER: each cycle, if multiplier[0] then acc += multiplicand<<count; shift multiplier right; count++. Exit after ITER_CYCLES; acc = p4 = hi*hi (32 bits).
  - FIX, one cycle:
    - mid = p1[31:16] + p2[15:0] + p3[15:0] (18 bits).
    - hi = p4 + p2[31:16] + p3[31:16] + mid[17:16], mod 2^32.
    - MULXSS: hi -= (src1[31] ? src2 : 0) + (src2[31] ? src1 : 0).
    - MULXSU: hi -= (src1[31] ? src2 : 0).
    - MULXUU: no correction.
  - DONE: A_mul_result=hi, A_mul_valid=1, A_mul_stall=0 in this cycle, return to IDLE.
  - Latency accept->valid: ITER_CYCLES+2 (18 cycles default).
- M_valid while state != IDLE: ignored. The upstream holds the instruction under stall, and the held instruction is re-accepted only once IDLE.
- A_en ignored outside IDLE. The engine always completes once started.
- A_mul_valid never asserts in the same cycle as A_mul_stall.

Optional Feature:
- Macro NIOS_MUL_HI_RADIX4_EN.
- Defined: ITER retires 2 multiplier bits per cycle using a 0/1x/2x/3x multiplicand adder (3x precomputed at accept). ITER_CYCLES=8; MULX latency 10.
- Undefined: radix-2 engine as above; ITER_CYCLES=16; MULX latency 18.
- MUL path and all results are identical in both builds.

Test Plan:
- MUL: src1=0x00012345, src2=0x00010000 -> A_mul_result=0x23450000, valid 1 cycle after accept, stall never high.
- MULXUU: 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE after 18 cycles (10 with macro); stall high exactly cycles 1..17 (1..9).
- MULXSS: 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000000. MULXSS: 0x80000000 * 0x80000000 -> 0x40000000.
- MULXSU: 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF. MULXSU: 0x7FFFFFFF * 0x00000002 -> 0x00000000.
- Back-to-back: MUL, MUL, MULXUU, MUL with M_valid held during stall -> results in order; second MUL accepted the cycle after the MULXUU valid; no duplicate valids.
- Reset mid-ITER (cycle 5 of MULXUU): all outputs 0 immediately; after release, a new MUL completes normally with no spurious valid.

Source files
------------

// File: rtl/nios_cpu_mul_combine.sv
// rtl/nios_cpu_mul_combine.sv - A-stage multiply result combiner with iterative hi*hi engine
// Optional macro NIOS_MUL_HI_RADIX4_EN selects the 2-bit-per-cycle hi*hi engine.
module nios_cpu_mul_combine (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  input  logic [31:0] M_src1,
  input  logic [31:0] M_src2,
  input  logic        M_valid,
  input  logic [1:0]  M_op,
  input  logic        A_en,
  output logic [31:0] A_mul_result,
  output logic        A_mul_valid,
  output logic        A_mul_stall
);

`ifdef NIOS_MUL_HI_RADIX4_EN
  localparam int ITER_CYCLES = 8;
`else
  localparam int ITER_CYCLES = 16;
`endif
  localparam logic [4:0] LAST_ITER = 5'(ITER_CYCLES - 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b10;
  localparam logic [1:0] OP_MULXSU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] p1_hi_q, p1_hi_d;
  logic [31:0] p2_q, p2_d;
  logic [31:0] p3_q, p3_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] result_q, result_d;
  logic        valid_q, valid_d;

  logic [31:0] mul_lo;
  logic [31:0] acc_add;
  logic [17:0] mid;
  logic [31:0] hi_sum;
  logic [31:0] hi_fix;
  logic [15:0] mplier_next;

`ifdef NIOS_MUL_HI_RADIX4_EN
  logic [17:0] mcand3_q, mcand3_d;
  logic [17:0] part;

  always_comb begin
    part = 18'd0;
    case (mplier_q[1:0])
      2'd1:    part = {2'b00, mcand_q};
      2'd2:    part = {1'b0, mcand_q, 1'b0};
      2'd3:    part = mcand3_q;
      default: part = 18'd0;
    endcase
    acc_add     = {14'd0, part} << {count_q, 1'b0};
    mplier_next = {2'b00, mplier_q[15:2]};
  end
`else
  always_comb begin
    acc_add     = mplier_q[0] ? ({16'd0, mcand_q} << count_q) : 32'd0;
    mplier_next = {1'b0, mplier_q[15:1]};
  end
`endif

  // Low word only needs the low halves of the cross products.
  assign mul_lo = M_mul_cell_p1 + {M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0], 16'd0};

  assign mid    = {2'b00, p1_hi_q} + {2'b00, p2_q[15:0]} + {2'b00, p3_q[15:0]};
  assign hi_sum = acc_q + {16'd0, p2_q[31:16]} + {16'd0, p3_q[31:16]} + {30'd0, mid[17:16]};

  // Signed views are recovered from the unsigned product by subtracting the
  // other operand wherever a negative operand's sign bit was weighted as +2^31.
  always_comb begin
    hi_fix = hi_sum;
    case (op_q)
      OP_MULXSS: hi_fix = hi_sum - (src1_q[31] ? src2_q : 32'd0)
                                 - (src2_q[31] ? src1_q : 32'd0);
      OP_MULXSU: hi_fix = hi_sum - (src1_q[31] ? src2_q : 32'd0);
      default:   hi_fix = hi_sum;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    op_d     = op_q;
    p1_hi_d  = p1_hi_q;
    p2_d     = p2_q;
    p3_d     = p3_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    valid_d  = 1'b0;
`ifdef NIOS_MUL_HI_RADIX4_EN
    mcand3_d = mcand3_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (M_valid && A_en) begin
          src1_d  = M_src1;
          src2_d  = M_src2;
          op_d    = M_op;
          p1_hi_d = M_mul_cell_p1[31:16];
          p2_d    = M_mul_cell_p2;
          p3_d    = M_mul_cell_p3;
          if (M_op == OP_MUL) begin
            result_d = mul_lo;
            valid_d  = 1'b1;
          end else begin
            state_d  = S_ITER;
            mcand_d  = M_src1[31:16];
            mplier_d = M_src2[31:16];
            acc_d    = 32'd0;
            count_d  = 5'd0;
`ifdef NIOS_MUL_HI_RADIX4_EN
            mcand3_d = {2'b00, M_src1[31:16]} + {1'b0, M_src1[31:16], 1'b0};
`endif
          end
        end
      end
      S_ITER: begin
        acc_d    = acc_q + acc_add;
        mplier_d = mplier_next;
        count_d  = count_q + 5'd1;
        if (count_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = hi_fix;
        valid_d  = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      src1_q   <= 32'd0;
      src2_q   <= 32'd0;
      op_q     <= 2'd0;
      p1_hi_q  <= 16'd0;
      p2_q     <= 32'd0;
      p3_q     <= 32'd0;
      mcand_q  <= 16'd0;
      mplier_q <= 16'd0;
      acc_q    <= 32'd0;
      count_q  <= 5'd0;
      result_q <= 32'd0;
      valid_q  <= 1'b0;
`ifdef NIOS_MUL_HI_RADIX4_EN
      mcand3_q <= 18'd0;
`endif
    end else begin
      state_q  <= state_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      op_q     <= op_d;
      p1_hi_q  <= p1_hi_d;
      p2_q     <= p2_d;
      p3_q     <= p3_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      valid_q  <= valid_d;
`ifdef NIOS_MUL_HI_RADIX4_EN
      mcand3_q <= mcand3_d;
`endif
    end
  end

  assign A_mul_result = result_q;
  assign A_mul_valid  = valid_q;
  assign A_mul_stall  = (state_q == S_ITER) || (state_q == S_FIX);

endmodule

// File: tb/tb_nios_cpu_mul_combine.sv
// tb/tb_nios_cpu_mul_combine.sv - scoreboard bench for nios_cpu_mul_combine
// Honours NIOS_MUL_HI_RADIX4_EN for the expected engine latency.
module tb_nios_cpu_mul_combine;

`ifdef NIOS_MUL_HI_RADIX4_EN
  localparam int ITER = 8;
`else
  localparam int ITER = 16;
`endif

  logic        clk;
  logic        reset_n;
  logic [31:0] M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3;
  logic [31:0] M_src1, M_src2;
  logic        M_valid;
  logic [1:0]  M_op;
  logic        A_en;
  logic [31:0] A_mul_result;
  logic        A_mul_valid;
  logic        A_mul_stall;

  nios_cpu_mul_combine dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .M_mul_cell_p1 (M_mul_cell_p1),
    .M_mul_cell_p2 (M_mul_cell_p2),
    .M_mul_cell_p3 (M_mul_cell_p3),
    .M_src1        (M_src1),
    .M_src2        (M_src2),
    .M_valid       (M_valid),
    .M_op          (M_op),
    .A_en          (A_en),
    .A_mul_result  (A_mul_result),
    .A_mul_valid   (A_mul_valid),
    .A_mul_stall   (A_mul_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          free_edge = 0;
  int          stall_lo = 0;
  int          stall_hi = -1;
  logic [31:0] last_result = 32'd0;
  logic        in_reset = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural product: full 64-bit multiply in the operand signedness the op names.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        prod;
    case (op)
      2'b10: begin
        sa   = $signed({{32{a[31]}}, a});
        sb   = $signed({{32{b[31]}}, b});
        prod = sa * sb;
      end
      2'b11: begin
        sa   = $signed({{32{a[31]}}, a});
        sb   = $signed({32'd0, b});
        prod = sa * sb;
      end
      default: prod = {32'd0, a} * {32'd0, b};
    endcase
    return (op == 2'b00) ? prod[31:0] : prod[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'h7FFFFFFF;
      3:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  task automatic note_accept(input logic [1:0] op, input logic [31:0] exp_res, input int edge_n);
    exp_t e;
    e.res = exp_res;
    if (op == 2'b00) begin
      e.cyc     = edge_n;
      free_edge = edge_n + 1;
    end else begin
      e.cyc     = edge_n + ITER + 1;
      stall_lo  = edge_n;
      stall_hi  = edge_n + ITER;
      free_edge = edge_n + ITER + 3;
    end
    exp_q.push_back(e);
  endtask

  // Called at a negedge; holds the instruction until the model says it is taken.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit use_exp, input logic [31:0] exp_res, input bit rand_en);
    int waited;
    logic [31:0] e;
    waited        = 0;
    e             = use_exp ? exp_res : ref_mul(op, a, b);
    M_src1        = a;
    M_src2        = b;
    M_op          = op;
    M_mul_cell_p1 = {16'd0, a[15:0]} * {16'd0, b[15:0]};
    M_mul_cell_p2 = {16'd0, a[15:0]} * {16'd0, b[31:16]};
    M_mul_cell_p3 = {16'd0, a[31:16]} * {16'd0, b[15:0]};
    M_valid       = 1'b1;
    forever begin
      A_en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (A_en && (cyc + 1 >= free_edge)) begin
        note_accept(op, e, cyc + 1);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      waited++;
      if (waited > 200) begin
        checks++;
        failures++;
        $display("FAIL issue_timeout: op %0d not taken within 200 cycles", op);
        break;
      end
    end
    M_valid = 1'b0;
    A_en    = rand_en ? $urandom_range(0, 1) : 1'b0;
  endtask

  task automatic gap(input int n);
    M_valid = 1'b0;
    repeat (n) begin
      A_en = $urandom_range(0, 1);
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (!in_reset) begin
      check("stall", {31'd0, A_mul_stall}, {31'd0, (cyc >= stall_lo) && (cyc <= stall_hi)});
      if (A_mul_valid && A_mul_stall) begin
        check("valid_with_stall", 32'd1, 32'd0);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missing_valid_cycle", 32'(cyc), 32'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      if (A_mul_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", A_mul_result, e.res);
          check("valid_cycle", 32'(cyc), 32'(e.cyc));
          last_result = e.res;
        end
      end else begin
        check("result_hold", A_mul_result, last_result);
      end
    end
  end

  initial begin
    int t;
    reset_n       = 1'b0;
    in_reset      = 1'b1;
    M_valid       = 1'b0;
    A_en          = 1'b0;
    M_op          = 2'd0;
    M_src1        = 32'd0;
    M_src2        = 32'd0;
    M_mul_cell_p1 = 32'd0;
    M_mul_cell_p2 = 32'd0;
    M_mul_cell_p3 = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_result", A_mul_result, 32'd0);
    check("reset_valid", {31'd0, A_mul_valid}, 32'd0);
    check("reset_stall", {31'd0, A_mul_stall}, 32'd0);
    reset_n  = 1'b1;
    in_reset = 1'b0;
    @(negedge clk);

    issue(2'b00, 32'h00012345, 32'h00010000, 1, 32'h23450000, 0);
    gap(2);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 0);
    issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, 0);
    issue(2'b10, 32'h80000000, 32'h80000000, 1, 32'h40000000, 0);
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0);
    issue(2'b11, 32'h7FFFFFFF, 32'h00000002, 1, 32'h00000000, 0);
    gap(3);

    issue(2'b00, 32'h00000003, 32'h00000005, 1, 32'h0000000F, 0);
    issue(2'b00, 32'h00010001, 32'h00010001, 1, 32'h00020001, 0);
    issue(2'b01, 32'h00020000, 32'h00030000, 1, 32'h00000006, 0);
    issue(2'b00, 32'hFFFFFFFF, 32'h00000002, 1, 32'hFFFFFFFE, 0);
    gap(3);

    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 0);
    repeat (5) @(negedge clk);
    in_reset = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("midreset_result", A_mul_result, 32'd0);
    check("midreset_valid", {31'd0, A_mul_valid}, 32'd0);
    check("midreset_stall", {31'd0, A_mul_stall}, 32'd0);
    exp_q.delete();
    free_edge   = 0;
    stall_lo    = 0;
    stall_hi    = -1;
    last_result = 32'd0;
    @(negedge clk);
    reset_n  = 1'b1;
    in_reset = 1'b0;
    @(negedge clk);
    issue(2'b00, 32'h00001234, 32'h00000010, 1, 32'h00012340, 0);
    gap(4);

    for (int i = 0; i < 60; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = (i % 3 == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      issue(op, a, b, 0, 32'd0, 1);
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
    end

    t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
